// File: rtl/pc_deserializer.sv
// pc_deserializer: hunts a start bit, reassembles back-to-back MSB-first PC frames into a valid/ready FIFO with stats.
module pc_deserializer #(
  parameter int PC_W       = 19,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             resync,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic             link_active,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow,
  input  logic             ovf_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(PC_W);
  typedef enum logic {HUNT, RECV} state_t;
  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [PC_W-2:0] shift_reg;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [PC_W-1:0] mem [FIFO_DEPTH];
  logic            empty, full, pop, push, do_push, drop;
  logic [PC_W-1:0] word;
  assign empty     = wr_ptr == rd_ptr;
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = !empty;
  assign out_pc    = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign pop       = out_valid && out_ready;
  assign word      = {shift_reg, serial_in};
  assign push      = state == RECV && bit_cnt == BW'(PC_W - 1);
  assign do_push   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign link_active = state == RECV;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= HUNT;
      bit_cnt   <= '0;
      shift_reg <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (state == HUNT) begin
        bit_cnt <= '0;
        if (serial_in) state <= RECV;
      end else begin
        shift_reg <= word[PC_W-2:0];
        bit_cnt   <= (push || resync) ? '0 : bit_cnt + 1'b1;
        if (resync) state <= HUNT;
      end
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      frame_cnt <= frame_cnt + CNT_W'(push);
      overflow  <= ovf_clr ? 1'b0 : (overflow | drop);
      if (ovf_clr) drop_cnt <= CNT_W'(drop);
      else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= word;
endmodule

// File: tb/tb_pc_deserializer.sv
// tb_pc_deserializer: directed-vector bench for pc_deserializer.
module tb_pc_deserializer;
  logic        clk = 1'b0, rst = 1'b1, serial_in = 1'b0, resync = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic        out_valid, link_active, overflow;
  logic [18:0] out_pc;
  logic [15:0] frame_cnt, drop_cnt;
  int          checks = 0, errors = 0;
  pc_deserializer dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .resync(resync),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .link_active(link_active), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic bit_t(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [18:0] v, input bit rs, input bit pl);
    for (int i = 18; i >= 0; i--) begin
      if (i == 0) begin
        resync = rs;
        if (pl) out_ready = 1'b1;
      end
      bit_t(v[i]);
    end
    resync = 1'b0;
    if (pl) out_ready = 1'b0;
    serial_in = 1'b0;
  endtask
  task automatic resync_cycle();
    resync = 1'b1;
    bit_t(1'b0);
    resync = 1'b0;
  endtask
  task automatic pop_chk(input string tag, input logic [18:0] exp);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, 32'(out_pc), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pc", 32'(out_pc), 0);
    chk("rst_link", 32'(link_active), 0);
    chk("rst_frames", 32'(frame_cnt), 0);
    chk("rst_drops", 32'(drop_cnt), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // single frame, consumer always ready
    out_ready = 1'b1;
    bit_t(0); bit_t(0); bit_t(1);
    chk("t1_link", 32'(link_active), 1);
    send_frame(19'h12345, 0, 0);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_pc", 32'(out_pc), 32'h12345);
    chk("t1_frames", 32'(frame_cnt), 1);
    resync_cycle();
    chk("t1_empty", 32'(out_valid), 0);
    chk("t1_hunt", 32'(link_active), 0);
    out_ready = 1'b0;
    // back-to-back frames
    bit_t(1);
    send_frame(19'h00001, 0, 0);
    send_frame(19'h7FFFF, 0, 0);
    send_frame(19'h40000, 0, 0);
    chk("t2_link", 32'(link_active), 1);
    chk("t2_frames", 32'(frame_cnt), 4);
    resync_cycle();
    pop_chk("t2_p0", 19'h00001);
    pop_chk("t2_p1", 19'h7FFFF);
    pop_chk("t2_p2", 19'h40000);
    chk("t2_empty", 32'(out_valid), 0);
    // overflow with consumer stalled
    bit_t(1);
    for (int k = 1; k <= 6; k++) send_frame(19'(k), k == 6, 0);
    chk("t3_drops", 32'(drop_cnt), 2);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_frames", 32'(frame_cnt), 10);
    for (int k = 1; k <= 4; k++) pop_chk("t3_pop", 19'(k));
    chk("t3_empty", 32'(out_valid), 0);
    ovf_clr = 1'b1;
    bit_t(0);
    ovf_clr = 1'b0;
    chk("t3_clr_ovf", 32'(overflow), 0);
    chk("t3_clr_drops", 32'(drop_cnt), 0);
    // resync mid-frame
    bit_t(1);
    repeat (10) bit_t(1);
    resync_cycle();
    chk("t4_link", 32'(link_active), 0);
    chk("t4_nopush", 32'(out_valid), 0);
    chk("t4_frames", 32'(frame_cnt), 10);
    bit_t(1);
    send_frame(19'h0ABCD, 1, 0);
    pop_chk("t4_pc", 19'h0ABCD);
    // resync coincident with the last bit
    bit_t(1);
    send_frame(19'h55555, 1, 0);
    chk("t5_link", 32'(link_active), 0);
    chk("t5_frames", 32'(frame_cnt), 12);
    pop_chk("t5_pc", 19'h55555);
    repeat (25) bit_t(0);
    chk("t5_idle_frames", 32'(frame_cnt), 12);
    chk("t5_idle_valid", 32'(out_valid), 0);
    // full FIFO with a pop on the completing edge
    bit_t(1);
    send_frame(19'h11, 0, 0);
    send_frame(19'h22, 0, 0);
    send_frame(19'h33, 0, 0);
    send_frame(19'h44, 0, 0);
    send_frame(19'h55, 1, 1);
    chk("t6_frames", 32'(frame_cnt), 17);
    chk("t6_drops", 32'(drop_cnt), 0);
    chk("t6_ovf", 32'(overflow), 0);
    pop_chk("t6_p0", 19'h22);
    pop_chk("t6_p1", 19'h33);
    pop_chk("t6_p2", 19'h44);
    pop_chk("t6_p3", 19'h55);
    chk("t6_empty", 32'(out_valid), 0);
    // async reset mid-frame
    bit_t(1);
    send_frame(19'h7, 0, 0);
    repeat (7) bit_t(1);
    chk("t7_pre_valid", 32'(out_valid), 1);
    chk("t7_pre_link", 32'(link_active), 1);
    serial_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t7_valid", 32'(out_valid), 0);
    chk("t7_pc", 32'(out_pc), 0);
    chk("t7_link", 32'(link_active), 0);
    chk("t7_frames", 32'(frame_cnt), 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    bit_t(1);
    send_frame(19'h3, 1, 0);
    chk("t7_frames_after", 32'(frame_cnt), 1);
    pop_chk("t7_pc_after", 19'h3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
